// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_pkg
//  Purpose  : Shared pipeline types for the MIPS memory-access stage:
//             control-bit bundle (shared with ex_stage), EX/MEM and MEM/WB
//             field bundles, word-size constant and a misalignment helper.
//  Ports    : n/a (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_OFF_W = $clog2(WORD_BYTES);

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  write_register;
        ctrl_t       ctrl;
    } exmem_t;

    // Read data is not part of this bundle: it is registered inside the
    // data memory and sits on the same MEM/WB boundary.
    typedef struct packed {
        logic [31:0] alu_result;
        logic [4:0]  write_register;
        logic        reg_write;
        logic        mem_to_reg;
        logic        misaligned;
    } memwb_t;

    // Only memory accesses can be misaligned; plain ALU results may have any
    // low bits.
    function automatic logic is_misaligned(input ctrl_t c,
                                           input logic [BYTE_OFF_W-1:0] off);
        return (c.mem_read | c.mem_write) && (off != '0);
    endfunction

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_if
//  Purpose  : Bundle of EX-side inputs, pipeline control and all result
//             outputs of the memory-access stage.
//  Ports    : master - drives i_* (execute stage / driver)
//             slave  - consumes i_*, drives o_* (mem_stage)
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
    logic        i_stall;
    logic        i_flush;
    logic [31:0] i_alu_result;
    logic [31:0] i_read_data_2;
    logic [4:0]  i_write_register;
    logic        i_reg_write;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        i_mem_to_reg;
    logic        i_branch;

    logic [31:0] o_exmem_alu_result;
    logic [4:0]  o_exmem_write_register;
    logic        o_exmem_reg_write;
    logic        o_exmem_branch;
    logic [31:0] o_wb_read_data;
    logic [31:0] o_wb_alu_result;
    logic [4:0]  o_wb_write_register;
    logic        o_wb_reg_write;
    logic        o_wb_mem_to_reg;
    logic        o_misaligned;

    modport master (
        output i_stall, i_flush, i_alu_result, i_read_data_2, i_write_register,
               i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_branch,
        input  o_exmem_alu_result, o_exmem_write_register, o_exmem_reg_write,
               o_exmem_branch, o_wb_read_data, o_wb_alu_result,
               o_wb_write_register, o_wb_reg_write, o_wb_mem_to_reg, o_misaligned
    );

    modport slave (
        input  i_stall, i_flush, i_alu_result, i_read_data_2, i_write_register,
               i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_branch,
        output o_exmem_alu_result, o_exmem_write_register, o_exmem_reg_write,
               o_exmem_branch, o_wb_read_data, o_wb_alu_result,
               o_wb_write_register, o_wb_reg_write, o_wb_mem_to_reg, o_misaligned
    );
endinterface : mem_stage_if
`default_nettype wire

// File: rtl/mem_stage_data_memory.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory
//  Purpose  : Word-addressed synchronous data RAM, one write and one read per
//             clock. The array itself is never reset.
//  Ports    : clk      - rising-edge clock
//             i_we     - write enable
//             i_re     - read enable; the read register holds when low
//             i_clr    - synchronous clear of the read register only
//             i_idx    - word index (shared by read and write)
//             i_wdata  - write data
//             o_rdata  - registered read data
//  Revision : 1.0 - initial release
// ============================================================================
module data_memory #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic              i_re,
    input  wire logic              i_clr,
    input  wire logic [ADDR_W-1:0] i_idx,
    input  wire logic [31:0]       i_wdata,
    output logic      [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Read register doubles as the MEM/WB read-data field, so it must honour
    // the pipeline's reset and stall. Same-index read/write returns old data;
    // the pipeline never relies on that case.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule : data_memory
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MIPS memory-access stage: EX/MEM pipeline register, data memory
//             access with misalignment detection, MEM/WB pipeline register.
//  Ports    : clk   - rising-edge clock
//             reset - synchronous active-high reset of both pipeline registers
//             bus   - mem_stage_if.slave: EX inputs, stall/flush, EX/MEM
//                     forwarding copies and MEM/WB results
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  wire logic  clk,
    input  wire logic  reset,
    mem_stage_if.slave bus
);

    exmem_t            w_exmem_in;
    exmem_t            r_exmem;
    memwb_t            w_memwb_in;
    memwb_t            r_memwb;
    logic              w_misaligned;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_idx;
    logic [31:0]       w_rdata;

    always_comb begin
        w_exmem_in                = '0;
        w_exmem_in.alu_result     = bus.i_alu_result;
        w_exmem_in.write_data     = bus.i_read_data_2;
        w_exmem_in.write_register = bus.i_write_register;
        w_exmem_in.ctrl.reg_write = bus.i_reg_write;
        w_exmem_in.ctrl.mem_read  = bus.i_mem_read;
        w_exmem_in.ctrl.mem_write = bus.i_mem_write;
        w_exmem_in.ctrl.mem_to_reg= bus.i_mem_to_reg;
        w_exmem_in.ctrl.branch    = bus.i_branch;
    end

    // Flush outranks stall: a bubble replaces whatever was held.
    always_ff @(posedge clk) begin
        if (reset || bus.i_flush) begin
            r_exmem <= '0;
        end else if (!bus.i_stall) begin
            r_exmem <= w_exmem_in;
        end
    end

    assign w_misaligned = is_misaligned(r_exmem.ctrl,
                                        r_exmem.alu_result[BYTE_OFF_W-1:0]);

    // Upper address bits are dropped, so addresses wrap over the array.
    assign w_mem_idx = r_exmem.alu_result[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];

    // A stalled store must not commit yet; it commits on its first free edge.
    assign w_mem_we = r_exmem.ctrl.mem_write & ~w_misaligned & ~bus.i_stall & ~reset;

    data_memory #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_re    (~bus.i_stall),
        .i_clr   (reset),
        .i_idx   (w_mem_idx),
        .i_wdata (r_exmem.write_data),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_memwb_in                = '0;
        w_memwb_in.alu_result     = r_exmem.alu_result;
        w_memwb_in.write_register = r_exmem.write_register;
        w_memwb_in.reg_write      = r_exmem.ctrl.reg_write & ~w_misaligned;
        w_memwb_in.mem_to_reg     = r_exmem.ctrl.mem_to_reg;
        w_memwb_in.misaligned     = w_misaligned;
    end

    // Flush deliberately does not touch MEM/WB: the instruction leaving
    // EX/MEM on the flush edge still completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_memwb <= '0;
        end else if (!bus.i_stall) begin
            r_memwb <= w_memwb_in;
        end
    end

    assign bus.o_exmem_alu_result     = r_exmem.alu_result;
    assign bus.o_exmem_write_register = r_exmem.write_register;
    assign bus.o_exmem_reg_write      = r_exmem.ctrl.reg_write;
    assign bus.o_exmem_branch         = r_exmem.ctrl.branch;
    assign bus.o_wb_read_data         = w_rdata;
    assign bus.o_wb_alu_result        = r_memwb.alu_result;
    assign bus.o_wb_write_register    = r_memwb.write_register;
    assign bus.o_wb_reg_write         = r_memwb.reg_write;
    assign bus.o_wb_mem_to_reg        = r_memwb.mem_to_reg;
    assign bus.o_misaligned           = r_memwb.misaligned;

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage: directed scenarios with
//             literal expectations plus randomized traffic against a
//             behavioural model of the stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_if bus ();

    mem_stage #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: memory image with a known-flag per word, plus the two slots.
    logic [31:0] m_mem   [256];
    bit          m_known [256];
    logic [31:0] mx_alu, mx_wd;
    logic [4:0]  mx_wr;
    bit          mx_rw, mx_mr, mx_mw, mx_m2r, mx_br;
    logic [31:0] mw_rd, mw_alu;
    logic [4:0]  mw_wr;
    bit          mw_rw, mw_m2r, mw_mis, mw_rd_chk;

    task automatic clear_ex();
        mx_alu = 0; mx_wd = 0; mx_wr = 0;
        mx_rw = 0; mx_mr = 0; mx_mw = 0; mx_m2r = 0; mx_br = 0;
    endtask

    // Advance the model by one clock edge using the inputs now on the bus.
    task automatic model_step();
        bit mis;
        int idx;
        if (reset) begin
            clear_ex();
            mw_rd = 0; mw_alu = 0; mw_wr = 0;
            mw_rw = 0; mw_m2r = 0; mw_mis = 0; mw_rd_chk = 1;
        end else begin
            mis = (mx_mr || mx_mw) && (mx_alu % 4 != 0);
            idx = int'((mx_alu / 4) % 256);
            if (!bus.i_stall) begin
                mw_rd     = m_mem[idx];
                mw_rd_chk = mx_mr && m_known[idx];
                mw_alu    = mx_alu;
                mw_wr     = mx_wr;
                mw_rw     = mx_rw && !mis;
                mw_m2r    = mx_m2r;
                mw_mis    = mis;
                if (mx_mw && !mis) begin
                    m_mem[idx]   = mx_wd;
                    m_known[idx] = 1;
                end
            end
            if (bus.i_flush) begin
                clear_ex();
            end else if (!bus.i_stall) begin
                mx_alu = bus.i_alu_result;  mx_wd = bus.i_read_data_2;
                mx_wr  = bus.i_write_register;
                mx_rw  = bus.i_reg_write;   mx_mr = bus.i_mem_read;
                mx_mw  = bus.i_mem_write;   mx_m2r = bus.i_mem_to_reg;
                mx_br  = bus.i_branch;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("exmem_alu",  bus.o_exmem_alu_result, mx_alu);
        chk("exmem_wr",   32'(bus.o_exmem_write_register), 32'(mx_wr));
        chk("exmem_rw",   32'(bus.o_exmem_reg_write), 32'(mx_rw));
        chk("exmem_br",   32'(bus.o_exmem_branch), 32'(mx_br));
        chk("wb_alu",     bus.o_wb_alu_result, mw_alu);
        chk("wb_wr",      32'(bus.o_wb_write_register), 32'(mw_wr));
        chk("wb_rw",      32'(bus.o_wb_reg_write), 32'(mw_rw));
        chk("wb_m2r",     32'(bus.o_wb_mem_to_reg), 32'(mw_m2r));
        chk("wb_mis",     32'(bus.o_misaligned), 32'(mw_mis));
        if (mw_rd_chk) chk("wb_rdata", bus.o_wb_read_data, mw_rd);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] wr,
                      input bit rw, input bit mr, input bit mw, input bit m2r,
                      input bit br, input bit st, input bit fl);
        bus.i_alu_result = a;   bus.i_read_data_2 = wd; bus.i_write_register = wr;
        bus.i_reg_write = rw;   bus.i_mem_read = mr;    bus.i_mem_write = mw;
        bus.i_mem_to_reg = m2r; bus.i_branch = br;
        bus.i_stall = st;       bus.i_flush = fl;
        tick();
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        op(a, d, 5'd0, 0, 0, 1, 0, 0, 0, 0);
    endtask
    task automatic lw(input logic [31:0] a, input logic [4:0] wr);
        op(a, 32'h0, wr, 1, 1, 0, 1, 0, 0, 0);
    endtask
    task automatic nop();
        op(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin m_mem[i] = 0; m_known[i] = 0; end
        clear_ex();
        mw_rd = 0; mw_alu = 0; mw_wr = 0; mw_rw = 0; mw_m2r = 0; mw_mis = 0; mw_rd_chk = 0;

        // Reset state
        reset = 1'b1;
        nop(); nop();
        chk("rst_exmem_alu", bus.o_exmem_alu_result, 32'h0);
        chk("rst_wb_rdata",  bus.o_wb_read_data, 32'h0);
        chk("rst_wb_rw",     32'(bus.o_wb_reg_write), 32'h0);
        reset = 1'b0;

        // Store then load
        sw(32'h10, 32'hDEADBEEF);
        lw(32'h10, 5'd5);
        nop();
        chk("sl_rdata", bus.o_wb_read_data, 32'hDEADBEEF);
        chk("sl_wr",    32'(bus.o_wb_write_register), 32'd5);
        chk("sl_rw",    32'(bus.o_wb_reg_write), 32'd1);
        chk("sl_m2r",   32'(bus.o_wb_mem_to_reg), 32'd1);

        // Misaligned store and load; word 4 keeps its value
        sw(32'h13, 32'h11111111);
        op(32'h12, 32'h0, 5'd3, 1, 1, 0, 1, 0, 0, 0);
        chk("mis_sw_flag", 32'(bus.o_misaligned), 32'd1);
        lw(32'h10, 5'd6);
        chk("mis_lw_flag", 32'(bus.o_misaligned), 32'd1);
        chk("mis_lw_rw",   32'(bus.o_wb_reg_write), 32'd0);
        nop();
        chk("mis_word4", bus.o_wb_read_data, 32'hDEADBEEF);

        // Stall: first store writes once after the stall, second overwrites
        sw(32'h20, 32'h1);
        for (int k = 0; k < 3; k++) begin
            op(32'h5555_5555, 32'hFFFF_FFFF, 5'd31, 1, 1, 1, 1, 1, 1, 0);
            chk("stall_exmem_alu", bus.o_exmem_alu_result, 32'h20);
        end
        lw(32'h20, 5'd9);
        nop();
        chk("stall_word8_a", bus.o_wb_read_data, 32'h1);
        sw(32'h20, 32'h2);
        lw(32'h20, 5'd9);
        nop();
        chk("stall_word8_b", bus.o_wb_read_data, 32'h2);

        // Flush on the capture edge
        sw(32'h40, 32'h1234);
        nop();
        op(32'h40, 32'hAA, 5'd0, 0, 0, 1, 0, 0, 0, 1);
        chk("flush_exmem_alu", bus.o_exmem_alu_result, 32'h0);
        nop();
        chk("flush_wb_rw", 32'(bus.o_wb_reg_write), 32'h0);
        lw(32'h40, 5'd4);
        nop();
        chk("flush_word16", bus.o_wb_read_data, 32'h1234);

        // Address wrap
        sw(32'h400, 32'h5);
        lw(32'h0, 5'd7);
        nop();
        chk("wrap_rdata", bus.o_wb_read_data, 32'h5);
        chk("wrap_wr",    32'(bus.o_wb_write_register), 32'd7);

        // Reset with a store pending in EX/MEM
        sw(32'h8, 32'h42);
        sw(32'h8, 32'h99);
        reset = 1'b1;
        nop();
        reset = 1'b0;
        chk("rstmid_exmem_alu", bus.o_exmem_alu_result, 32'h0);
        chk("rstmid_wb_alu",    bus.o_wb_alu_result, 32'h0);
        chk("rstmid_wb_rdata",  bus.o_wb_read_data, 32'h0);
        chk("rstmid_mis",       32'(bus.o_misaligned), 32'h0);
        lw(32'h8, 5'd2);
        nop();
        chk("rstmid_word2", bus.o_wb_read_data, 32'h42);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            int kind;
            reset = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) != 0) a = {$urandom_range(0, 1023), 2'b00};
            else                           a = $urandom_range(0, 32'hFFF);
            kind = $urandom_range(0, 3);
            op(a, $urandom, 5'($urandom),
               (kind == 1) || (kind == 3), kind == 1, kind == 2, kind == 1,
               1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end
        reset = 1'b0;
        nop(); nop(); nop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_stage
`default_nettype wire
